// File: rtl/uart_fifo_ctrl.sv
// UART host controller: bus registers, RX/TX byte FIFOs and a TX launcher FSM.
// Define UART_FIFO_OVERRUN_EN to add the RX overrun flag (STATUS bit6) and its interrupt.
module uart_fifo_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy_,
  output logic              irq_rx,
  output logic              irq_tx,
  input  logic              rx_busy,
  input  logic              rx_end,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  input  logic              tx_end,
  output logic              tx_start,
  output logic [7:0]        tx_data
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]     DepthC     = CW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] AddrStatus = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrData   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrCtrl   = ADDR_W'(2);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2} txState_e;

  logic [7:0]        rxMem [FIFO_DEPTH];
  logic [7:0]        txMem [FIFO_DEPTH];
  logic [AW-1:0]     rxWrPtr_q, rxWrPtr_d, rxRdPtr_q, rxRdPtr_d;
  logic [AW-1:0]     txWrPtr_q, txWrPtr_d, txRdPtr_q, txRdPtr_d;
  logic [CW-1:0]     rxCount_q, rxCount_d, txCount_q, txCount_d;
  logic              rxPend_q, rxPend_d, txPend_q, txPend_d;
  logic              rxIe_q, rxIe_d, txIe_q, txIe_d;
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic              rdy_q, irqRx_q, irqRx_d, irqTx_q;
  txState_e          txState_q;
  logic              txStart_q;
  logic [7:0]        txData_q;

  logic              access, rdAcc, wrAcc, selStatus, selData, selCtrl, w1cWrite;
  logic              rxEmpty, rxFull, txEmpty, txFull;
  logic              rxPop, rxPush, txPush, txPop, rxFlush, txFlush, txDone;
  logic [DATA_W-1:0] statusWord;
  logic              unusedWrBits;

  assign access    = !cs_ && !as_;
  assign rdAcc     = access && rw;
  assign wrAcc     = access && !rw;
  assign selStatus = addr == AddrStatus;
  assign selData   = addr == AddrData;
  assign selCtrl   = addr == AddrCtrl;
  assign w1cWrite  = wrAcc && selStatus;

  assign rxEmpty = rxCount_q == '0;
  assign rxFull  = rxCount_q == DepthC;
  assign txEmpty = txCount_q == '0;
  assign txFull  = txCount_q == DepthC;

  // A pop in the same cycle frees a slot, so a full RX FIFO still accepts the byte.
  assign rxFlush = wrAcc && selCtrl && wr_data[2];
  assign txFlush = wrAcc && selCtrl && wr_data[3];
  assign rxPop   = rdAcc && selData && !rxEmpty;
  assign rxPush  = rx_end && (!rxFull || rxPop) && !rxFlush;
  assign txPush  = wrAcc && selData && !txFull;
  assign txPop   = (txState_q == SEND) && !txEmpty;
  assign txDone  = tx_end && (txState_q == WAIT) && txEmpty;

  assign unusedWrBits = ^wr_data[DATA_W-1:8];

`ifdef UART_FIFO_OVERRUN_EN
  logic overrun_q, overrun_d, rxDrop;
  assign rxDrop    = rx_end && rxFull && !rxPop;
  assign overrun_d = rxDrop | (overrun_q & !(w1cWrite & wr_data[6]));
  assign irqRx_d   = (rxPend_q & rxIe_q) | overrun_q;

  always_ff @(posedge clk) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end
`else
  assign irqRx_d = rxPend_q & rxIe_q;
`endif

  always_comb begin
    statusWord        = '0;
    statusWord[0]     = rxPend_q;
    statusWord[1]     = txPend_q;
    statusWord[2]     = rx_busy;
    statusWord[3]     = tx_busy;
    statusWord[4]     = rxEmpty;
    statusWord[5]     = txFull;
`ifdef UART_FIFO_OVERRUN_EN
    statusWord[6]     = overrun_q;
`endif
    statusWord[15:8]  = 8'(rxCount_q);
    statusWord[23:16] = 8'(txCount_q);
  end

  always_comb begin
    rdData_d = '0;
    if (rdAcc) begin
      if (selStatus)               rdData_d = statusWord;
      else if (selData && !rxEmpty) rdData_d = DATA_W'(rxMem[rxRdPtr_q]);
      else if (selCtrl)            rdData_d = DATA_W'({txIe_q, rxIe_q});
    end
  end

  // Flushes win over any push or pop landing in the same cycle.
  always_comb begin
    rxWrPtr_d = rxWrPtr_q;
    rxRdPtr_d = rxRdPtr_q;
    txWrPtr_d = txWrPtr_q;
    txRdPtr_d = txRdPtr_q;
    if (rxPush) rxWrPtr_d = rxWrPtr_q + AW'(1);
    if (rxPop)  rxRdPtr_d = rxRdPtr_q + AW'(1);
    if (txPush) txWrPtr_d = txWrPtr_q + AW'(1);
    if (txPop)  txRdPtr_d = txRdPtr_q + AW'(1);
    rxCount_d = rxCount_q + CW'(rxPush) - CW'(rxPop);
    txCount_d = txCount_q + CW'(txPush) - CW'(txPop);
    if (rxFlush) begin
      rxWrPtr_d = '0;
      rxRdPtr_d = '0;
      rxCount_d = '0;
    end
    if (txFlush) begin
      txWrPtr_d = '0;
      txRdPtr_d = '0;
      txCount_d = '0;
    end
  end

  always_comb begin
    rxPend_d = rxPush | (rxPend_q & !(w1cWrite & wr_data[0]));
    txPend_d = txDone | (txPend_q & !(w1cWrite & wr_data[1]));
    rxIe_d   = rxIe_q;
    txIe_d   = txIe_q;
    if (wrAcc && selCtrl) begin
      rxIe_d = wr_data[0];
      txIe_d = wr_data[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxWrPtr_q <= '0;
      rxRdPtr_q <= '0;
      txWrPtr_q <= '0;
      txRdPtr_q <= '0;
      rxCount_q <= '0;
      txCount_q <= '0;
      rxPend_q  <= 1'b0;
      txPend_q  <= 1'b0;
      rxIe_q    <= 1'b0;
      txIe_q    <= 1'b0;
      rdData_q  <= '0;
      rdy_q     <= 1'b1;
      irqRx_q   <= 1'b0;
      irqTx_q   <= 1'b0;
    end else begin
      rxWrPtr_q <= rxWrPtr_d;
      rxRdPtr_q <= rxRdPtr_d;
      txWrPtr_q <= txWrPtr_d;
      txRdPtr_q <= txRdPtr_d;
      rxCount_q <= rxCount_d;
      txCount_q <= txCount_d;
      rxPend_q  <= rxPend_d;
      txPend_q  <= txPend_d;
      rxIe_q    <= rxIe_d;
      txIe_q    <= txIe_d;
      rdData_q  <= rdData_d;
      rdy_q     <= !access;
      irqRx_q   <= irqRx_d;
      irqTx_q   <= txPend_q & txIe_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rxPush) rxMem[rxWrPtr_q] <= rx_data;
    if (txPush) txMem[txWrPtr_q] <= wr_data[7:0];
  end

  // The head byte is latched on entry to SEND; the FIFO pop happens during SEND.
  always_ff @(posedge clk) begin
    if (reset) begin
      txState_q <= IDLE;
      txStart_q <= 1'b0;
      txData_q  <= '0;
    end else begin
      txStart_q <= 1'b0;
      txData_q  <= '0;
      case (txState_q)
        IDLE: begin
          if (!txEmpty && !tx_busy && !txFlush) begin
            txState_q <= SEND;
            txStart_q <= 1'b1;
            txData_q  <= txMem[txRdPtr_q];
          end
        end
        SEND:    txState_q <= WAIT;
        WAIT:    if (tx_end) txState_q <= IDLE;
        default: txState_q <= IDLE;
      endcase
    end
  end

  assign rd_data  = rdData_q;
  assign rdy_     = rdy_q;
  assign irq_rx   = irqRx_q;
  assign irq_tx   = irqTx_q;
  assign tx_start = txStart_q;
  assign tx_data  = txData_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl: scoreboards for TX launches and RX pops.
// Honours UART_FIFO_OVERRUN_EN when deciding the expected STATUS overrun bit.
module tb_uart_fifo_ctrl;
  localparam int FifoDepth = 8;
`ifdef UART_FIFO_OVERRUN_EN
  localparam logic [31:0] OvrBit = 32'h40;
`else
  localparam logic [31:0] OvrBit = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset, cs_, as_, rw, rx_busy, rx_end, tx_busy, tx_end;
  logic [1:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        rdy_, irq_rx, irq_tx, tx_start;
  logic [7:0]  rx_data, tx_data;

  int          compareCount = 0;
  int          mismatchCount = 0;
  int          txStartSeen = 0;
  logic [7:0]  txExpQ[$];
  logic [7:0]  rxExpQ[$];

  uart_fifo_ctrl #(.FIFO_DEPTH(FifoDepth), .ADDR_W(2), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .irq_rx(irq_rx), .irq_tx(irq_tx),
    .rx_busy(rx_busy), .rx_end(rx_end), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_end(tx_end), .tx_start(tx_start), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Each launch must carry the oldest byte still owed to the transmitter.
  always @(negedge clk) begin
    if (!reset && tx_start) begin
      txStartSeen++;
      if (txExpQ.size() == 0) checkOutput("txStartUnexpected", 32'd1, 32'd0);
      else                    checkOutput("txData", {24'd0, tx_data}, {24'd0, txExpQ.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
    tick();
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; wr_data = '0;
    checkOutput("wrRdy", {31'd0, rdy_}, 32'd0);
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a;
    tick();
    cs_ = 1'b1; as_ = 1'b1;
    d = rd_data;
    checkOutput("rdRdy", {31'd0, rdy_}, 32'd0);
  endtask

  task automatic readExpect(input logic [1:0] a, input logic [31:0] expected, input string tag);
    logic [31:0] v;
    busRead(a, v);
    checkOutput(tag, v, expected);
  endtask

  task automatic readData();
    logic [31:0] v;
    busRead(2'd1, v);
    if (rxExpQ.size() > 0) checkOutput("rxByte", v, {24'd0, rxExpQ.pop_front()});
    else                   checkOutput("rxEmptyRead", v, 32'd0);
  endtask

  task automatic txWrite(input logic [7:0] b);
    busWrite(2'd1, {24'd0, b});
    if (txExpQ.size() < FifoDepth) txExpQ.push_back(b);
  endtask

  task automatic rxByte(input logic [7:0] b);
    rx_data = b; rx_end = 1'b1;
    tick();
    rx_end = 1'b0;
    if (rxExpQ.size() < FifoDepth) rxExpQ.push_back(b);
  endtask

  task automatic pulseTxEnd();
    tx_end = 1'b1;
    tick();
    tx_end = 1'b0;
  endtask

  task automatic waitStarts(input int target);
    for (int i = 0; i < 50 && txStartSeen < target; i++) tick();
    checkOutput("txStartCount", txStartSeen, target);
  endtask

  task automatic applyStimulus();
    logic [7:0] popped;
    // Reset values
    repeat (3) tick();
    checkOutput("rstRdData", rd_data, 32'd0);
    checkOutput("rstRdy", {31'd0, rdy_}, 32'd1);
    checkOutput("rstIrq", {30'd0, irq_rx, irq_tx}, 32'd0);
    checkOutput("rstTxStart", {31'd0, tx_start}, 32'd0);
    checkOutput("rstTxData", {24'd0, tx_data}, 32'd0);
    reset = 1'b0;
    tick();
    readExpect(2'd0, 32'h10, "statusAfterReset");

    // Two-byte transmit, second launch only after the first tx_end
    txWrite(8'h41);
    txWrite(8'h42);
    waitStarts(1);
    checkOutput("txDataIdle", {24'd0, tx_data}, 32'd0);
    repeat (3) tick();
    checkOutput("txHeldUntilEnd", txStartSeen, 1);
    pulseTxEnd();
    waitStarts(2);
    repeat (2) tick();
    pulseTxEnd();
    readExpect(2'd0, 32'h12, "txPendAfterDrain");
    busWrite(2'd0, 32'h2);
    readExpect(2'd0, 32'h10, "txPendCleared");

    // RX interrupt and its W1C clear
    busWrite(2'd2, 32'h1);
    readExpect(2'd2, 32'h1, "ctrlRead");
    rxByte(8'h55);
    tick();
    checkOutput("irqRxSet", {31'd0, irq_rx}, 32'd1);
    busWrite(2'd0, 32'h1);
    tick();
    checkOutput("irqRxCleared", {31'd0, irq_rx}, 32'd0);
    readData();
    busWrite(2'd2, 32'h0);

    // Nine bytes into an eight-deep RX FIFO
    for (int i = 0; i < 9; i++) rxByte(8'(8'h10 + i));
    readExpect(2'd0, 32'h0801 | OvrBit, "rxOverflowStatus");
    busWrite(2'd0, 32'h41);
    readExpect(2'd0, 32'h0800, "rxFlagsCleared");

    // Pop and push together on a full RX FIFO
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = 2'd1;
    rx_end = 1'b1; rx_data = 8'h99;
    tick();
    cs_ = 1'b1; as_ = 1'b1; rx_end = 1'b0;
    popped = rxExpQ.pop_front();
    rxExpQ.push_back(8'h99);
    checkOutput("popPushData", rd_data, {24'd0, popped});
    readExpect(2'd0, 32'h0801, "popPushStatus");
    for (int i = 0; i < FifoDepth + 1; i++) readData();
    readExpect(2'd0, 32'h11, "rxDrained");
    busWrite(2'd0, 32'h1);

    // Unmapped address
    busWrite(2'd3, 32'hFFFF_FFFF);
    readExpect(2'd3, 32'h0, "addr3Read");
    readExpect(2'd0, 32'h10, "addr3NoEffect");

    // TX full boundary, then flush
    tx_busy = 1'b1;
    for (int i = 0; i < 9; i++) txWrite(8'(8'hA0 + i));
    readExpect(2'd0, 32'h0008_0038, "txFullStatus");
    busWrite(2'd2, 32'h8);
    txExpQ.delete();
    readExpect(2'd0, 32'h18, "txFlushFull");

    // Flush with three entries queued, then no launches
    for (int i = 0; i < 3; i++) txWrite(8'(8'hB0 + i));
    readExpect(2'd0, 32'h0003_0018, "tx3Queued");
    busWrite(2'd2, 32'h8);
    txExpQ.delete();
    readExpect(2'd0, 32'h18, "txFlush3");
    tx_busy = 1'b0;
    repeat (20) tick();
    checkOutput("noStartAfterFlush", txStartSeen, 2);

    // Reset while waiting for tx_end
    txWrite(8'h77);
    waitStarts(3);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    checkOutput("wrstTxStart", {31'd0, tx_start}, 32'd0);
    checkOutput("wrstRdy", {31'd0, rdy_}, 32'd1);
    checkOutput("wrstTxData", {24'd0, tx_data}, 32'd0);
    tick();
    reset = 1'b0;
    pulseTxEnd();
    tick();
    readExpect(2'd0, 32'h10, "wrstStatus");
    txWrite(8'h88);
    waitStarts(4);
    repeat (2) tick();
    pulseTxEnd();
    readExpect(2'd0, 32'h12, "txAfterReset");
  endtask

  initial begin
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0;
    rx_busy = 1'b0; rx_end = 1'b0; rx_data = '0; tx_busy = 1'b0; tx_end = 1'b0;
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
